mandelbrot_result_merge: RTL and testbench
==========================================

Name: mandelbrot_result_merge

Overview:
- Collects results from NCH parallel mandelbrot engines into one video-memory write stream. This is the multi-engine successor of the single-engine result path in the top level.
- Per input: round-robin arbitration, an internal sync FIFO, and frame accounting with start/busy/done.
- Sits between the engine array and the vram write port of the video pipe, all in one clock domain. A CDC FIFO, if needed, goes downstream.

Parameters:
- NCH, 4, number of engine channels (1..16)
- AW, 19, pixel address width
- DW, 8, iteration/index data width
- FD, 8, internal FIFO depth (power of 2, ≥2)
- NPIXELS, 307200, pixels per frame (writes that complete a frame)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  clock enable; all state frozen when low
- start  in  1  pulse: begin a frame (accepted only in IDLE/DONE)
- ch_mask  in  NCH  per-channel enable; masked channels are never granted
- busy  out  1  frame in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when the last frame write is issued
- in_vld  in  NCH  per-channel result valid
- in_rdy  out  NCH  per-channel ready (one-hot or zero)
- in_dat  in  NCH*DW  channel i occupies [i*DW +: DW]
- in_adr  in  NCH*AW  channel i occupies [i*AW +: AW]
- vram_we  out  1  video memory write enable (registered)
- vram_adr_w  out  AW  write address (registered)
- vram_dat_w  out  DW  write data (registered)
- acc_cnt  out  $clog2(NPIXELS+1)  results accepted this frame

Behaviour:
- Reset (async, rst=1):
  - state IDLE; FIFO empty; rr pointer 0; acc_cnt 0; write counter 0.
  - busy, done, vram_we, in_rdy all 0; vram_adr_w and vram_dat_w 0.
- States:
  - IDLE -> RUN on start. This transition clears acc_cnt and the write counter.
  - RUN -> DRAIN on the edge where acc_cnt reaches NPIXELS.
  - DRAIN -> DONE on the edge issuing write number NPIXELS; done=1 for that one cycle.
  - DONE -> RUN on start; otherwise hold.
  - start in RUN or DRAIN is ignored.
- Arbitration (RUN only, FIFO not full):
  - Grant goes to the first i with in_vld[i]&ch_mask[i], searching from the rr pointer upward and wrapping modulo NCH.
  - in_rdy[grant]=1 combinationally; all other in_rdy are 0.
  - After an accepted handshake, rr pointer = grant+1 mod NCH. With no handshake, the pointer holds.
- FIFO full, or not in RUN: in_rdy = 0; in_vld is ignored.
- Handshake at enabled edge k writes {adr,dat} to the FIFO and increments acc_cnt.
- Output stage:
  - When the FIFO is non-empty on an enabled edge, one entry is popped into the output registers with vram_we=1 for that cycle.
  - Otherwise vram_we=0 and adr/dat hold.
  - Latency: accept edge k -> vram_we high after edge k+1.
  - Sustained throughput is 1 pixel per enabled cycle.
  - Simultaneous push and pop on a full FIFO is not possible: push requires not-full. Push and pop in the same cycle on a non-empty FIFO leaves the count unchanged.
- Draining continues in every state. The FIFO is never flushed except by reset.
- clk_en=0:
  - All registers hold, including vram_we. The downstream qualifies with clk_en.
  - in_rdy forced 0.
- Wrap: acc_cnt and the write counter saturate at NPIXELS; no address wrap checking is done.
- Reset mid-frame discards FIFO contents. Engines must be reset together with this block.

Decomposition:
- mandelbrot_pkg holds:
  - widths AW and DW;
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - a packed result struct {adr,dat}.
- One sub-module, sync_fifo (parametrised DW, FD; ports wr_en/in/rd_en/out/empty/full), with clk_en gating.
- The arbiter stays inline: a priority search from the rr pointer.

Test Plan:
- Single channel, NPIXELS=4: start, ch0 drives adr 0..3 / dat 0x10..0x13 -> vram_we on 4 consecutive cycles, each starting one edge after its accept; done pulses once on the 4th write; busy falls with it.
- NCH=4, all in_vld held high, NPIXELS=8 -> grant order 0,1,2,3,0,1,2,3; acc_cnt=8; state DRAIN then DONE.
- ch_mask=4'b1010, all valid -> only ch1 and ch3 accepted, alternating; in_rdy[0] and in_rdy[2] stay 0.
- FD=4, clk_en toggled 1/0 and FIFO filled while clk_en=0 periods stall the pop -> in_rdy=0 while full; no data lost or duplicated; write order equals accept order.
- start pulsed in RUN -> ignored, acc_cnt not cleared; start in DONE -> counters cleared, new frame runs.
- rst asserted mid-frame with 3 entries in the FIFO -> outputs 0 immediately; vram_we stays 0 after rst releases; state IDLE.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types for the multi-engine mandelbrot result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mandelbrot_pkg;

  localparam int AW = 19;  // pixel address width
  localparam int DW = 8;   // iteration/index data width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One engine result as it travels towards the vram write port.
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } result_t;

endpackage

// File: rtl/mandelbrot_result_merge_sync_fifo.sv
// Single-clock FIFO, first-word fall-through: out shows the head entry whenever !empty.
// Latency: a push at edge k is visible on out after edge k.
// Backpressure: pushes are dropped when full, pops are ignored when empty; clk_en=0 freezes all state.
// Ports: clk/rst/clk_en control; wr_en+in push side; rd_en+out pop side; empty/full status.
module sync_fifo #(
  parameter int DW = 8,
  parameter int FD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          wr_en,
  input  logic [DW-1:0] in,
  input  logic          rd_en,
  output logic [DW-1:0] out,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(FD);

  logic [DW-1:0] mem [FD];
  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          push, pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
               (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    push     = clk_en && wr_en && !full;
    pop      = clk_en && rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + {{PW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + {{PW{1'b0}}, 1'b1} : rd_ptr_q;
    out      = mem[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PW-1:0]] <= in;
  end

endmodule

// File: rtl/mandelbrot_result_merge.sv
// Merges NCH engine result streams (round-robin) into one registered vram write stream with frame accounting.
// Latency: accept at edge k -> vram_we high after edge k+1; 1 pixel per enabled cycle sustained.
// Backpressure: in_rdy only in RUN with FIFO not full and clk_en high; output side has none (pops every enabled cycle).
// Ports: clk/rst/clk_en; start/busy/done frame control; ch_mask, in_vld/in_rdy/in_dat/in_adr
//        per-engine inputs; vram_we/vram_adr_w/vram_dat_w write port; acc_cnt accepted-this-frame.
module mandelbrot_result_merge #(
  parameter int NCH     = 4,
  parameter int AW      = mandelbrot_pkg::AW,
  parameter int DW      = mandelbrot_pkg::DW,
  parameter int FD      = 8,
  parameter int NPIXELS = 307200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [NCH-1:0]               ch_mask,
  output logic                         busy,
  output logic                         done,
  input  logic [NCH-1:0]               in_vld,
  output logic [NCH-1:0]               in_rdy,
  input  logic [NCH*DW-1:0]            in_dat,
  input  logic [NCH*AW-1:0]            in_adr,
  output logic                         vram_we,
  output logic [AW-1:0]                vram_adr_w,
  output logic [DW-1:0]                vram_dat_w,
  output logic [$clog2(NPIXELS+1)-1:0] acc_cnt
);

  import mandelbrot_pkg::*;

  localparam int CW  = $clog2(NPIXELS+1);
  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;

  // Widths follow this instance's parameters, which may differ from the package defaults.
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } res_t;

  state_t         state_q, state_d;
  logic [RRW-1:0] rr_q, rr_d;
  logic [CW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  wr_q, wr_d;
  logic           done_q, done_d;
  logic           we_q, we_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [DW-1:0]  dat_q, dat_d;

  logic [NCH-1:0] req;
  logic [RRW-1:0] grant;
  logic           grant_vld;
  logic           accept_ok, hs, pop, clr;
  res_t           fifo_in, fifo_out;
  logic           fifo_empty, fifo_full;

  // Priority search starting at rr_q. Walking offsets downward lets the
  // smallest offset (closest to rr_q) be the last, winning assignment.
  always_comb begin
    int idx;
    idx       = 0;
    req       = in_vld & ch_mask;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NCH;
      if (req[idx]) begin
        grant     = RRW'(idx);
        grant_vld = 1'b1;
      end
    end
    accept_ok = clk_en && (state_q == ST_RUN) && !fifo_full;
    hs        = accept_ok && grant_vld;
    pop       = clk_en && !fifo_empty;
    fifo_in   = '{adr: in_adr[int'(grant)*AW +: AW], dat: in_dat[int'(grant)*DW +: DW]};
  end

  sync_fifo #(
    .DW (AW+DW),
    .FD (FD)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .wr_en  (hs),
    .in     (fifo_in),
    .rd_en  (1'b1),
    .out    (fifo_out),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else if (clk_en) state_q <= state_d;
  end

  // FSM: next state. done_d marks the edge that issues the final write.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (hs && acc_q == CW'(NPIXELS-1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && wr_q == CW'(NPIXELS-1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    in_rdy = hs ? (NCH'(1) << grant) : '0;
  end

  // Counters, round-robin pointer and output register next values.
  always_comb begin
    acc_d = acc_q;
    wr_d  = wr_q;
    if (clr) begin
      acc_d = '0;
      wr_d  = '0;
    end else begin
      if (hs  && acc_q != CW'(NPIXELS)) acc_d = acc_q + CW'(1);
      if (pop && wr_q  != CW'(NPIXELS)) wr_d  = wr_q  + CW'(1);
    end
    rr_d = rr_q;
    if (hs) rr_d = (grant == RRW'(NCH-1)) ? '0 : grant + RRW'(1);
    we_d  = pop;
    adr_d = pop ? fifo_out.adr : adr_q;
    dat_d = pop ? fifo_out.dat : dat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= '0;
      acc_q  <= '0;
      wr_q   <= '0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
    end else if (clk_en) begin
      rr_q   <= rr_d;
      acc_q  <= acc_d;
      wr_q   <= wr_d;
      done_q <= done_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
    end
  end

  assign done       = done_q;
  assign vram_we    = we_q;
  assign vram_adr_w = adr_q;
  assign vram_dat_w = dat_q;
  assign acc_cnt    = acc_q;

endmodule

// File: tb/tb_mandelbrot_result_merge.sv
// Randomized scoreboard bench for mandelbrot_result_merge (NCH=4, FD=4, NPIXELS=8).
// Latency: expected writes queued at accept time, popped by an independent monitor.
// Backpressure: in_rdy is predicted each cycle from a frame-level reference model.
module tb_mandelbrot_result_merge;

  localparam int NCH = 4;
  localparam int AW  = 19;
  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int NP  = 8;
  localparam int CW  = $clog2(NP+1);

  logic              clk = 1'b0;
  logic              rst, clk_en, start;
  logic [NCH-1:0]    ch_mask, in_vld, in_rdy;
  logic [NCH*DW-1:0] in_dat;
  logic [NCH*AW-1:0] in_adr;
  logic              busy, done, vram_we;
  logic [AW-1:0]     vram_adr_w;
  logic [DW-1:0]     vram_dat_w;
  logic [CW-1:0]     acc_cnt;

  always #5 clk = ~clk;

  mandelbrot_result_merge #(
    .NCH(NCH), .AW(AW), .DW(DW), .FD(FD), .NPIXELS(NP)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .ch_mask(ch_mask),
    .busy(busy), .done(done), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_dat(in_dat), .in_adr(in_adr), .vram_we(vram_we),
    .vram_adr_w(vram_adr_w), .vram_dat_w(vram_dat_w), .acc_cnt(acc_cnt)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: frame phase 0=idle 1=run 2=drain 3=done, plus counts.
  int   m_state, m_acc, m_wr, m_occ, m_rr;
  bit   m_done, m_we;
  logic [AW+DW-1:0] exp_q[$];
  int   dut_g[$];

  function automatic int pick(input logic [NCH-1:0] v, input int rr);
    int r;
    r = -1;
    for (int k = 0; k < NCH; k++)
      if (r < 0 && v[(rr + k) % NCH]) r = (rr + k) % NCH;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_wr = 0; m_occ = 0; m_rr = 0;
    m_done = 1'b0; m_we = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: check registered outputs, drive inputs, check in_rdy, advance model.
  task automatic cycle(input bit en, input bit st, input logic [NCH-1:0] vld);
    int  g;
    bit  ok, pop, nd;
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    check("busy", busy, (m_state == 1 || m_state == 2));
    check("done", done, m_done);
    check("acc_cnt", acc_cnt, m_acc);
    check("vram_we", vram_we, m_we);
    clk_en = en;
    start  = st;
    in_vld = vld;
    for (int i = 0; i < NCH; i++) begin
      in_dat[i*DW +: DW] = DW'($urandom);
      in_adr[i*AW +: AW] = AW'($urandom);
    end
    #1;
    g  = pick(in_vld & ch_mask, m_rr);
    ok = en && (m_state == 1) && (m_occ < FD) && (g >= 0);
    exp_rdy = ok ? NCH'(1 << g) : '0;
    check("in_rdy", in_rdy, exp_rdy);
    for (int i = 0; i < NCH; i++) if (in_rdy[i]) dut_g.push_back(i);
    if (en) begin
      pop = (m_occ > 0);
      nd  = 1'b0;
      if (pop) begin
        m_occ--;
        if (m_wr < NP) m_wr++;
      end
      if (ok) begin
        exp_q.push_back({in_adr[g*AW +: AW], in_dat[g*DW +: DW]});
        m_occ++;
        if (m_acc < NP) m_acc++;
        m_rr = (g + 1) % NCH;
      end
      case (m_state)
        0, 3: if (st) begin m_state = 1; m_acc = 0; m_wr = 0; end
        1: if (ok && m_acc == NP) m_state = 2;
        2: if (pop && m_wr == NP) begin m_state = 3; nd = 1'b1; end
        default: ;
      endcase
      m_done = nd;
      m_we   = pop;
    end
  endtask

  // mode 0: all valid, clk_en high. mode 1: random valid, random clk_en, stray starts.
  task automatic run_frame(input logic [NCH-1:0] mask, input int mode);
    int n;
    ch_mask = mask;
    dut_g.delete();
    cycle(1'b1, 1'b1, (mode == 0) ? '1 : NCH'($urandom));
    n = 0;
    while (m_state != 3 && n < 300) begin
      if (mode == 0)
        cycle(1'b1, ($urandom_range(0, 9) == 0), '1);
      else
        cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), NCH'($urandom));
      n++;
    end
    if (m_state != 3) check("frame_timeout", n, -1);
    else check("acc_final", acc_cnt, NP);
  endtask

  // Monitor: every enabled edge with vram_we high must match the oldest accepted result.
  initial begin
    logic en_s;
    logic [AW+DW-1:0] e;
    forever begin
      @(posedge clk);
      en_s = clk_en;
      #1;
      if (en_s && !rst && vram_we) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("vram_adr_w", vram_adr_w, e[AW+DW-1:DW]);
          check("vram_dat_w", vram_dat_w, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; start = 1'b0; ch_mask = '0;
    in_vld = '0; in_dat = '0; in_adr = '0;
    model_reset();
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", vram_we, 0);
    check("rst_rdy", in_rdy, 0);
    check("rst_adr", vram_adr_w, 0);
    check("rst_dat", vram_dat_w, 0);
    check("rst_acc", acc_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    ch_mask = '1;
    repeat (3) cycle(1'b1, 1'b0, '1);  // IDLE: no grants

    run_frame(4'b1111, 0);
    check("order_len_1111", dut_g.size(), NP);
    for (int k = 0; k < dut_g.size() && k < NP; k++) check("grant_order_1111", dut_g[k], k % 4);

    run_frame(4'b1010, 0);
    check("order_len_1010", dut_g.size(), NP);
    for (int k = 0; k < dut_g.size() && k < NP; k++)
      check("grant_order_1010", dut_g[k], (k % 2 == 0) ? 1 : 3);

    for (int f = 0; f < 4; f++) begin
      logic [NCH-1:0] m;
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      run_frame(m, 1);
    end

    // Reset in the middle of a frame.
    ch_mask = '1;
    cycle(1'b1, 1'b1, '1);
    repeat (4) cycle(1'b1, 1'b0, '1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_we", vram_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", in_rdy, 0);
    check("midrst_acc", acc_cnt, 0);
    check("midrst_adr", vram_adr_w, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, '1);

    run_frame(4'b0110, 1);
    repeat (5) cycle(1'b1, 1'b0, '0);
    check("leftover_expected", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
